dickson_debounce_in: RTL and testbench
======================================

DICKSON_DEBOUNCE_IN -- requirements
Module: dickson_debounce_in

Interface
REQ-001 SHALL provide parameter W, default 4, number of input channels, legal range 1..4.
REQ-002 SHALL provide parameter MS_DIV, default 100000, clk cycles per 1 ms tick.
REQ-003 SHALL provide parameter DB_RST, default 20, reset value of the debounce-time register in ms.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cs  input  1  slot select.
REQ-007 SHALL have port read  input  1  read strobe; no side effects.
REQ-008 SHALL have port write  input  1  write strobe; a write occurs when cs && write.
REQ-009 SHALL have port addr  input  5  register address.
REQ-010 SHALL have port wr_data  input  32  write data.
REQ-011 SHALL have port rd_data  output  32  combinational read data selected by addr.
REQ-012 SHALL have port btn_in  input  W  asynchronous raw button/switch inputs.
REQ-013 SHALL have port irq  output  1  registered interrupt request.

Function
REQ-014 SHALL pass each btn_in bit through a 2-flop synchronizer before any other use.
REQ-015 SHALL run a free prescaler 0..MS_DIV-1, wrapping to 0, with tick=1 for the cycle the prescaler equals MS_DIV-1.
REQ-016 SHALL keep, per channel, a stable bit and a 16-bit counter: sync==stable -> cnt<=0; else if cnt>=db_ms -> stable<=sync, cnt<=0; else if tick -> cnt<=cnt+1.
REQ-017 SHALL use the current db_ms value in each cycle's compare, so lowering db_ms mid-count releases a pending change on the next cycle.
REQ-018 SHALL, with db_ms=0, update stable the cycle after sync differs.
REQ-019 SHALL set rise[i] on a stable 0->1 transition and fall[i] on a stable 1->0 transition; flags are sticky.
REQ-020 SHALL increment an 8-bit cnt_press[i] on each stable 0->1 transition, wrapping 255->0.
REQ-021 SHALL decode the register map: addr 0 RO stable[W-1:0]; addr 1 rise flags, W1C; addr 2 fall flags, W1C; addr 3 db_ms[15:0] RW; addr 4 RO-packed cnt_press, channel i at bits [8i+7:8i], any write clears all counters; addr 5 irq_en[2W-1:0] RW, with rise enables at [W-1:0] and fall enables at [2W-1:W].
REQ-022 SHALL return 0 in unused rd_data bits and for addr 6..31; writes to addr 0 and 6..31 SHALL be ignored.
REQ-023 SHALL, when a flag set and a W1C clear of the same bit coincide, leave the flag set.
REQ-024 SHALL, when a press increment and a counter-clear write coincide, leave that counter at 1.
REQ-025 SHALL register irq <= |({fall,rise} & irq_en), so irq follows flag and enable changes with 1-cycle latency.

Reset
REQ-026 SHALL, on reset, clear synchronizers, prescaler, stable, debounce counters, rise, fall, cnt_press, irq_en and irq to 0, and set db_ms to DB_RST.
REQ-027 SHALL, if reset is asserted mid-debounce, discard the pending change; after release an input held at 1 SHALL take a full db_ms interval to appear as stable=1, and SHALL set rise and increment its counter.

Verification
REQ-028 SHALL, with MS_DIV=10 and db_ms=3, hold btn_in[0]=1 -> addr 0 reads 0x1 within 2+3*10+10 cycles; addr 1 reads 0x1; addr 4 reads 0x01.
REQ-029 SHALL, with MS_DIV=10 and db_ms=3, drive a bounce of 1 for 15 cycles, 0 for 5 cycles, then 1 held -> no stable change until 30+ cycles after the last edge; exactly one rise.
REQ-030 SHALL, with rise[2] set, write 0x4 to addr 1 -> reads 0; a coincident new rise[2] event -> reads 0x4.
REQ-031 SHALL, with irq_en=0x01 and a press on channel 0 -> irq=1 one cycle after rise[0] sets; W1C to addr 1 -> irq=0 one cycle later.
REQ-032 SHALL, after 256 presses on channel 1 -> addr 4 bits [15:8] read 0x00; 257 presses -> 0x01; write to addr 4 -> 0x00000000.
REQ-033 SHALL, with db_ms=0 -> stable follows sync 1 cycle later; with db_ms lowered from 100 to 2 mid-count at cnt=5 -> stable updates the next cycle.

Source files
------------

// File: rtl/dickson_debounce_in.sv
// dickson_debounce_in
//   Debounced button/switch input block with a small register slot.
//   Raw inputs are synchronised, debounced against a millisecond tick and
//   turned into sticky rise/fall flags, per-channel press counters and an
//   interrupt request.
//
//   Ports
//     clk      system clock, all state on rising edge
//     reset    asynchronous active-high reset
//     cs       slot select
//     read     read strobe (no side effects)
//     write    write strobe; a write happens when cs && write
//     addr     register address
//     wr_data  write data
//     rd_data  combinational read data selected by addr
//     btn_in   raw asynchronous button inputs
//     irq      registered interrupt request
//
//   Register map
//     0 stable (RO)   1 rise (W1C)   2 fall (W1C)   3 db_ms (RW, 16 bit)
//     4 packed press counters (RO, any write clears)   5 irq_en (RW)
module dickson_debounce_in #(
   parameter int unsigned W      = 4,
   parameter int unsigned MS_DIV = 100000,
   parameter int unsigned DB_RST = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [4:0]    addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   input  logic [W-1:0]  btn_in,
   output logic          irq
);

   localparam int unsigned PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

   logic [W-1:0]   r_sync1;
   logic [W-1:0]   r_sync2;
   logic [PW-1:0]  r_pre;
   logic [W-1:0]   r_stable;
   logic [15:0]    r_cnt [W];
   logic [7:0]     r_press [W];
   logic [W-1:0]   r_rise;
   logic [W-1:0]   r_fall;
   logic [15:0]    r_db_ms;
   logic [2*W-1:0] r_irq_en;
   logic           r_irq;

   logic           w_tick;
   logic           w_wr;
   logic [W-1:0]   w_chg;
   logic [W-1:0]   w_rise_evt;
   logic [W-1:0]   w_fall_evt;
   logic [W-1:0]   w_rise_clr;
   logic [W-1:0]   w_fall_clr;
   logic           w_clr_press;
   logic [31:0]    w_press_pack;
   logic           w_unused;

   assign w_unused = &{1'b0, read, wr_data[31:16]};

   assign w_tick      = (r_pre == PW'(MS_DIV - 1));
   assign w_wr        = cs & write;
   assign w_rise_clr  = (w_wr && addr == 5'd1) ? wr_data[W-1:0] : '0;
   assign w_fall_clr  = (w_wr && addr == 5'd2) ? wr_data[W-1:0] : '0;
   assign w_clr_press = w_wr && (addr == 5'd4);

   // A channel commits when its synchronised level has disagreed with the
   // stable level for at least db_ms ticks; the live db_ms is used so that
   // lowering it releases a pending change immediately.
   always_comb begin
      w_chg      = '0;
      w_rise_evt = '0;
      w_fall_evt = '0;
      for (int unsigned i = 0; i < W; i++) begin
         w_chg[i]      = (r_sync2[i] != r_stable[i]) && (r_cnt[i] >= r_db_ms);
         w_rise_evt[i] = w_chg[i] & r_sync2[i];
         w_fall_evt[i] = w_chg[i] & ~r_sync2[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_pre   <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
         r_pre   <= w_tick ? '0 : r_pre + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stable <= '0;
         r_rise   <= '0;
         r_fall   <= '0;
         r_db_ms  <= 16'(DB_RST);
         r_irq_en <= '0;
         r_irq    <= 1'b0;
         for (int unsigned i = 0; i < W; i++) begin
            r_cnt[i]   <= '0;
            r_press[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < W; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (w_chg[i]) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else if (w_tick) begin
               r_cnt[i] <= r_cnt[i] + 16'd1;
            end

            // A press landing on the clearing write still counts once.
            if (w_clr_press) begin
               r_press[i] <= w_rise_evt[i] ? 8'd1 : 8'd0;
            end else if (w_rise_evt[i]) begin
               r_press[i] <= r_press[i] + 8'd1;
            end
         end

         // New events win over a coincident W1C of the same bit.
         r_rise <= (r_rise & ~w_rise_clr) | w_rise_evt;
         r_fall <= (r_fall & ~w_fall_clr) | w_fall_evt;

         if (w_wr && addr == 5'd3) begin
            r_db_ms <= wr_data[15:0];
         end
         if (w_wr && addr == 5'd5) begin
            r_irq_en <= wr_data[2*W-1:0];
         end

         r_irq <= |({r_fall, r_rise} & r_irq_en);
      end
   end

   always_comb begin
      w_press_pack = '0;
      for (int unsigned i = 0; i < W; i++) begin
         w_press_pack[8*i +: 8] = r_press[i];
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         5'd0: rd_data[W-1:0]   = r_stable;
         5'd1: rd_data[W-1:0]   = r_rise;
         5'd2: rd_data[W-1:0]   = r_fall;
         5'd3: rd_data[15:0]    = r_db_ms;
         5'd4: rd_data          = w_press_pack;
         5'd5: rd_data[2*W-1:0] = r_irq_en;
         default: rd_data       = '0;
      endcase
   end

   assign irq = r_irq;

endmodule

// File: tb/tb_dickson_debounce_in.sv
module tb_dickson_debounce_in;

   localparam int MSD = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic [3:0]  btn_in = '0;
   logic        irq;

   int n_chk = 0;
   int n_pass = 0;

   // Behavioural model state
   bit [3:0] m_s1, m_s2, m_stable, m_rise, m_fall;
   bit [7:0] m_en;
   bit       m_irq;
   int       m_pre, m_db;
   int       m_cnt [4];
   int       m_press [4];

   dickson_debounce_in #(.W(4), .MS_DIV(MSD), .DB_RST(20)) dut (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .btn_in(btn_in), .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_edge();
      bit [3:0] er, ef;
      bit tick, wr;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
         m_en = '0; m_irq = 1'b0; m_pre = 0; m_db = 20;
         for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_press[i] = 0; end
         return;
      end
      wr   = cs && write;
      tick = (m_pre == MSD - 1);
      m_irq = (({m_fall, m_rise} & m_en) != 0);
      er = '0; ef = '0;
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] == m_stable[i]) m_cnt[i] = 0;
         else if (m_cnt[i] >= m_db) begin
            m_stable[i] = m_s2[i];
            m_cnt[i] = 0;
            if (m_s2[i]) er[i] = 1'b1; else ef[i] = 1'b1;
         end else if (tick) m_cnt[i] = m_cnt[i] + 1;
      end
      m_rise = (wr && addr == 1) ? ((m_rise & ~wr_data[3:0]) | er) : (m_rise | er);
      m_fall = (wr && addr == 2) ? ((m_fall & ~wr_data[3:0]) | ef) : (m_fall | ef);
      for (int i = 0; i < 4; i++) begin
         if (wr && addr == 4) m_press[i] = er[i] ? 1 : 0;
         else if (er[i]) m_press[i] = (m_press[i] + 1) % 256;
      end
      if (wr && addr == 3) m_db = int'(wr_data[15:0]);
      if (wr && addr == 5) m_en = wr_data[7:0];
      m_s2 = m_s1;
      m_s1 = btn_in;
      m_pre = tick ? 0 : m_pre + 1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      case (a)
         5'd0: return {28'd0, m_stable};
         5'd1: return {28'd0, m_rise};
         5'd2: return {28'd0, m_fall};
         5'd3: return 32'(m_db);
         5'd4: return {m_press[3][7:0], m_press[2][7:0], m_press[1][7:0], m_press[0][7:0]};
         5'd5: return {24'd0, m_en};
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         model_edge();
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("rd_data_model", rd_data, exp_rd(addr));
         chk("irq_model", {31'd0, irq}, {31'd0, m_irq});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
      step();
      cs = 1'b0; write = 1'b0; wr_data = '0;
   endtask

   task automatic chk_rd(input string name, input logic [4:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(name, d & mask, exp);
   endtask

   task automatic wait_bit(input string name, input int b, input bit v, input int budget);
      logic [31:0] d;
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         step();
         rd(5'd0, d);
         if (d[b] == v) ok = 1'b1;
      end
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: stable[%0d] did not reach %0b within %0d cycles", name, b, v, budget);
   endtask

   task automatic hold_bit(input string name, input int b, input bit v, input int n);
      logic [31:0] d;
      for (int k = 0; k < n; k++) begin
         step();
         rd(5'd0, d);
         chk(name, {31'd0, d[b]}, {31'd0, v});
      end
   endtask

   task automatic press(input int ch);
      btn_in[ch] = 1'b1;
      repeat (4) step();
      btn_in[ch] = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      bit found;
      // reset state
      repeat (2) step();
      reset = 1'b0;
      chk_rd("reset_db_ms", 5'd3, 32'hFFFF_FFFF, 32'd20);
      chk_rd("reset_stable", 5'd0, 32'hFFFF_FFFF, 32'd0);
      chk_rd("reset_press", 5'd4, 32'hFFFF_FFFF, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);

      // single held press, db_ms = 3
      wr(5'd3, 32'd3);
      btn_in[0] = 1'b1;
      wait_bit("hold_to_stable", 0, 1'b1, 42);
      chk_rd("hold_rise", 5'd1, 32'hFFFF_FFFF, 32'h1);
      chk_rd("hold_press", 5'd4, 32'hFFFF_FFFF, 32'h01);

      // writes to RO / unmapped addresses are ignored
      wr(5'd0, 32'hFFFF_FFFF);
      wr(5'd7, 32'hFFFF_FFFF);
      chk_rd("ro_write_ignored", 5'd0, 32'hFFFF_FFFF, 32'h1);
      chk_rd("unmapped_reads_zero", 5'd7, 32'hFFFF_FFFF, 32'h0);

      // bounce: 15 cycles high, 5 low, then held
      btn_in[0] = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      wr(5'd3, 32'd3);
      btn_in[0] = 1'b1;
      repeat (15) step();
      btn_in[0] = 1'b0;
      repeat (5) step();
      btn_in[0] = 1'b1;
      hold_bit("bounce_no_early_change", 0, 1'b0, 22);
      wait_bit("bounce_settles", 0, 1'b1, 30);
      chk_rd("bounce_one_press", 5'd4, 32'hFFFF_FFFF, 32'h01);

      // reset mid-debounce discards the pending change
      btn_in[0] = 1'b0;
      wait_bit("release_ch0", 0, 1'b0, 45);
      wr(5'd1, 32'hF);
      btn_in[0] = 1'b1;
      repeat (15) step();
      reset = 1'b1;
      step();
      chk_rd("in_reset_stable", 5'd0, 32'hFFFF_FFFF, 32'h0);
      reset = 1'b0;
      wr(5'd3, 32'd3);
      hold_bit("post_reset_full_interval", 0, 1'b0, 20);
      wait_bit("post_reset_settles", 0, 1'b1, 30);
      chk_rd("post_reset_rise", 5'd1, 32'h1, 32'h1);
      chk_rd("post_reset_press", 5'd4, 32'hFF, 32'h01);

      // W1C and set-wins coincidence on rise[2], db_ms = 0
      wr(5'd3, 32'd0);
      btn_in[2] = 1'b1;
      wait_bit("ch2_up", 2, 1'b1, 5);
      chk_rd("rise2_set", 5'd1, 32'h4, 32'h4);
      wr(5'd1, 32'h4);
      chk_rd("rise2_w1c", 5'd1, 32'h4, 32'h0);
      btn_in[2] = 1'b0;
      wait_bit("ch2_down", 2, 1'b0, 5);
      btn_in[2] = 1'b1;
      wait_bit("ch2_up2", 2, 1'b1, 5);
      btn_in[2] = 1'b0;
      wait_bit("ch2_down2", 2, 1'b0, 5);
      btn_in[2] = 1'b1;
      step();
      step();
      wr(5'd1, 32'h4);
      chk_rd("rise2_set_wins", 5'd1, 32'h4, 32'h4);

      // irq latency
      wr(5'd5, 32'h01);
      btn_in[0] = 1'b0;
      wait_bit("ch0_down", 0, 1'b0, 5);
      wr(5'd1, 32'hF);
      step();
      chk("irq_idle", {31'd0, irq}, 32'd0);
      btn_in[0] = 1'b1;
      repeat (3) step();
      chk_rd("irq_rise0", 5'd1, 32'h1, 32'h1);
      chk("irq_not_yet", {31'd0, irq}, 32'd0);
      step();
      chk("irq_asserted", {31'd0, irq}, 32'd1);
      wr(5'd1, 32'h1);
      chk("irq_still_high", {31'd0, irq}, 32'd1);
      step();
      chk("irq_cleared", {31'd0, irq}, 32'd0);

      // press counter wrap on channel 1
      wr(5'd4, 32'd0);
      for (int p = 0; p < 256; p++) press(1);
      chk_rd("press_256_wraps", 5'd4, 32'h0000_FF00, 32'h0);
      press(1);
      chk_rd("press_257", 5'd4, 32'h0000_FF00, 32'h0000_0100);
      wr(5'd4, 32'd0);
      chk_rd("press_clear", 5'd4, 32'hFFFF_FFFF, 32'h0);
      btn_in[1] = 1'b1;
      step();
      step();
      wr(5'd4, 32'd0);
      chk_rd("press_clear_coincide", 5'd4, 32'hFFFF_FFFF, 32'h0000_0100);
      btn_in[1] = 1'b0;
      wait_bit("ch1_down", 1, 1'b0, 5);

      // db_ms = 0 follows sync one cycle later
      btn_in[3] = 1'b1;
      step();
      step();
      chk_rd("db0_not_yet", 5'd0, 32'h8, 32'h0);
      step();
      chk_rd("db0_follows", 5'd0, 32'h8, 32'h8);

      // lowering db_ms mid-count releases next cycle
      wr(5'd3, 32'd100);
      btn_in[3] = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (m_cnt[3] == 5) found = 1'b1;
      end
      chk("reach_cnt5", {31'd0, found}, 32'd1);
      wr(5'd3, 32'd2);
      chk_rd("lower_db_pending", 5'd0, 32'h8, 32'h8);
      step();
      chk_rd("lower_db_released", 5'd0, 32'h8, 32'h0);

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
